pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage core (IF/ID/EX/MEM/WB).
- Decides per-cycle stall/flush controls for PC, IF/ID, ID/EX and EX/MEM registers.
- Generates the PC redirect for taken branches/jumps resolved in EX.
- Holds the whole pipe while data memory is busy, with a timeout guard.

Parameters:
MEM_TIMEOUT, 15, max consecutive MEM-wait cycles before abort (1..255)
CNT_W, 8, width of internal wait counter (must hold MEM_TIMEOUT)

Ports:
clk  in  1  core clock, rising edge
rst  in  1  synchronous active-low reset (`RST = 1'b0 asserts)
id_rs1_raddr  in  5  rs1 address of instruction in ID
id_rs2_raddr  in  5  rs2 address of instruction in ID
id_rs1_used  in  1  ID instruction reads rs1
id_rs2_used  in  1  ID instruction reads rs2
ex_rd_waddr  in  5  rd of instruction in EX
ex_mem_rw  in  2  EX mem op: 2'b01 load, 2'b10 store, 2'b00 none
ex_br_taken  in  1  EX branch/jump resolved taken
ex_br_target  in  32  EX redirect address
mem_req  in  1  MEM stage has an active data access
mem_ready  in  1  data memory completes access this cycle
jump_flag_o  out  1  PC loads jump_addr_o next edge
jump_addr_o  out  32  redirect target
stall_pc_o  out  1  hold PC
stall_if_id_o  out  1  hold IF/ID
stall_id_ex_o  out  1  hold ID/EX
stall_ex_mem_o  out  1  hold EX/MEM
flush_if_id_o  out  1  load bubble into IF/ID
flush_id_ex_o  out  1  load bubble into ID/EX
timeout_err_o  out  1  sticky: a MEM access was aborted
perf_stall_cnt_o  out  32  stall-cycle count (optional feature)
perf_flush_cnt_o  out  32  redirect count (optional feature)

Behaviour:
- Registered state: RUN, FLUSH, MEM_WAIT; wait counter; timeout_err_o. All other outputs combinational from state and inputs.
- Reset (rst==0 at edge): state=RUN, counter=0, timeout_err_o=0, perf counters=0. While rst==0, all outputs forced 0 and jump_addr_o=32'b0. Reset mid-MEM_WAIT abandons wait immediately.
- Priority per cycle: MEM wait > branch redirect > load-use.
- mem_wait = mem_req & ~mem_ready. In RUN or FLUSH with mem_wait: assert all four stalls, no flush, no jump; next state MEM_WAIT, counter=1.
- MEM_WAIT: all four stalls asserted while mem_wait. Counter +1 per cycle. mem_ready=1: stalls released same cycle, -> RUN. Counter reaches MEM_TIMEOUT with mem_wait: release stalls, set timeout_err_o (sticky until reset), flush_id_ex_o=1 that cycle, -> RUN.
- Redirect (RUN, no mem_wait, ex_br_taken=1): jump_flag_o=1, jump_addr_o=ex_br_target, flush_if_id_o=1, flush_id_ex_o=1, -> FLUSH. Branch arriving during MEM_WAIT is held by stall_ex_mem_o/stall_id_ex_o and acted on the first non-wait cycle.
- FLUSH (1 cycle, covers synchronous instruction-memory latency): flush_if_id_o=1. Load-use ignored. ex_br_taken ignored (EX holds a bubble). -> RUN unless mem_wait.
- Load-use (RUN only, no mem_wait, no redirect): ex_mem_rw==2'b01, ex_rd_waddr!=0, and (id_rs1_used & rs1==rd | id_rs2_used & rs2==rd). Asserts stall_pc_o, stall_if_id_o, flush_id_ex_o for exactly that cycle. No state change.
- Stores (2'b10) and rd==x0 never cause a load-use stall.
- A stall and a flush on the same register are never asserted together.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: perf_stall_cnt_o += 1 each cycle stall_pc_o=1; perf_flush_cnt_o += 1 each cycle jump_flag_o=1. Both 32-bit, saturate at 32'hFFFFFFFF, cleared by reset.
- Undefined: counter logic absent; both ports drive 32'b0.

Test Plan:
- Load-use: ex_mem_rw=01, ex_rd=5'd31, id_rs1=31, rs1_used=1 -> one cycle stall_pc/stall_if_id/flush_id_ex=1; rd=0 or ex_mem_rw=10 -> no stall.
- Redirect: ex_br_taken=1, target=32'h0000_0100 -> cycle0 jump_flag=1, jump_addr=0x100, both flushes; cycle1 flush_if_id only; cycle2 all 0.
- MEM wait: mem_req=1, mem_ready=0 for 4 cycles then 1 -> all stalls high 4 cycles, low on ready cycle, timeout_err=0.
- Timeout: MEM_TIMEOUT=15, mem_ready held 0 -> stalls released on 15th wait cycle, flush_id_ex=1, timeout_err=1 and stays 1 until rst=0.
- Priority: ex_br_taken=1 and load-use and mem_wait together -> only stalls; after mem_ready, redirect fires, no load-use stall.
- Reset mid-wait: rst=0 in MEM_WAIT -> next cycle all outputs 0, state RUN; with HAZARD_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: per-cycle stall/flush controls, EX branch redirect and MEM-wait hold with timeout.
// Optional performance counters are compiled in when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_raddr,
  input  logic [4:0]  id_rs2_raddr,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  ex_rd_waddr,
  input  logic [1:0]  ex_mem_rw,
  input  logic        ex_br_taken,
  input  logic [31:0] ex_br_target,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic        stall_pc_o,
  output logic        stall_if_id_o,
  output logic        stall_id_ex_o,
  output logic        stall_ex_mem_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic        timeout_err_o,
  output logic [31:0] perf_stall_cnt_o,
  output logic [31:0] perf_flush_cnt_o
);

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_MEM_WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             terr_q, terr_d;
  logic             mem_wait, load_use, timeout_hit;

  assign mem_wait    = mem_req & ~mem_ready;
  assign load_use    = (ex_mem_rw == 2'b01) && (ex_rd_waddr != 5'd0) &&
                       ((id_rs1_used && (id_rs1_raddr == ex_rd_waddr)) ||
                        (id_rs2_used && (id_rs2_raddr == ex_rd_waddr)));
  // The cycle entering MEM_WAIT already counts as wait cycle 1.
  assign timeout_hit = (state_q == ST_MEM_WAIT) && (cnt_q >= CNT_LAST);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    terr_d         = terr_q;
    jump_flag_o    = 1'b0;
    jump_addr_o    = 32'b0;
    stall_pc_o     = 1'b0;
    stall_if_id_o  = 1'b0;
    stall_id_ex_o  = 1'b0;
    stall_ex_mem_o = 1'b0;
    flush_if_id_o  = 1'b0;
    flush_id_ex_o  = 1'b0;
    if (!rst) begin
      state_d = ST_RUN;
      cnt_d   = '0;
      terr_d  = 1'b0;
    end else if (mem_wait && !timeout_hit) begin
      stall_pc_o     = 1'b1;
      stall_if_id_o  = 1'b1;
      stall_id_ex_o  = 1'b1;
      stall_ex_mem_o = 1'b1;
      state_d        = ST_MEM_WAIT;
      cnt_d          = (state_q == ST_MEM_WAIT) ? cnt_q + CNT_W'(1) : CNT_W'(1);
    end else if (mem_wait) begin
      flush_id_ex_o = 1'b1;
      terr_d        = 1'b1;
      state_d       = ST_RUN;
      cnt_d         = '0;
    end else if (state_q == ST_FLUSH) begin
      // EX holds a bubble and IF output is stale: ignore branch and load-use.
      flush_if_id_o = 1'b1;
      state_d       = ST_RUN;
    end else begin
      // RUN, or the release cycle of MEM_WAIT, where a held branch now fires.
      state_d = ST_RUN;
      cnt_d   = '0;
      if (ex_br_taken) begin
        jump_flag_o   = 1'b1;
        jump_addr_o   = ex_br_target;
        flush_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
        state_d       = ST_FLUSH;
      end else if (load_use) begin
        stall_pc_o    = 1'b1;
        stall_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
      end
    end
  end

  assign timeout_err_o = rst & terr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (stall_pc_o && (perf_stall_q != 32'hFFFF_FFFF))
      perf_stall_d = perf_stall_q + 32'd1;
    if (jump_flag_o && (perf_flush_q != 32'hFFFF_FFFF))
      perf_flush_d = perf_flush_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_stall_q <= 32'b0;
      perf_flush_q <= 32'b0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cnt_o = rst ? perf_stall_q : 32'b0;
  assign perf_flush_cnt_o = rst ? perf_flush_q : 32'b0;
`else
  assign perf_stall_cnt_o = 32'b0;
  assign perf_flush_cnt_o = 32'b0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized scoreboard bench for pipe_hazard_ctrl: a driver predicts each cycle's outputs
// from the hazard rules and queues them; a monitor compares what the DUT presents.
module tb_pipe_hazard_ctrl;
  localparam int MEM_TIMEOUT = 15;
  localparam int NCYC        = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1_raddr, id_rs2_raddr, ex_rd_waddr;
  logic        id_rs1_used, id_rs2_used;
  logic [1:0]  ex_mem_rw;
  logic        ex_br_taken;
  logic [31:0] ex_br_target;
  logic        mem_req, mem_ready;
  logic        jump_flag_o, stall_pc_o, stall_if_id_o, stall_id_ex_o, stall_ex_mem_o;
  logic        flush_if_id_o, flush_id_ex_o, timeout_err_o;
  logic [31:0] jump_addr_o, perf_stall_cnt_o, perf_flush_cnt_o;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_raddr(id_rs1_raddr), .id_rs2_raddr(id_rs2_raddr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd_waddr(ex_rd_waddr), .ex_mem_rw(ex_mem_rw),
    .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o),
    .stall_pc_o(stall_pc_o), .stall_if_id_o(stall_if_id_o),
    .stall_id_ex_o(stall_id_ex_o), .stall_ex_mem_o(stall_ex_mem_o),
    .flush_if_id_o(flush_if_id_o), .flush_id_ex_o(flush_id_ex_o),
    .timeout_err_o(timeout_err_o),
    .perf_stall_cnt_o(perf_stall_cnt_o), .perf_flush_cnt_o(perf_flush_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [7:0]  ctrl;  // {jump, stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex, terr}
    logic [31:0] addr;
    logic [63:0] perf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state: consecutive wait cycles, pending fetch flush, sticky error, counters.
  int          streak;
  bit          flushing;
  bit          terr;
  logic [31:0] m_stall, m_flush;

  function automatic logic [4:0] pick_reg();
    int r;
    r = $urandom_range(0, 3);
    return (r == 3) ? 5'd31 : 5'(r);
  endfunction

  task automatic check(input string name, input int cyc, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, req);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ctrl", e.cyc,
              {56'b0, jump_flag_o, stall_pc_o, stall_if_id_o, stall_id_ex_o, stall_ex_mem_o,
               flush_if_id_o, flush_id_ex_o, timeout_err_o}, {56'b0, e.ctrl});
        check("jump_addr", e.cyc, {32'b0, jump_addr_o}, {32'b0, e.addr});
        check("perf", e.cyc, {perf_stall_cnt_o, perf_flush_cnt_o}, e.perf);
      end
    end
  end

  initial begin : driver
    exp_t e;
    bit   mw, lu, jf, spc, sif, sid, sem, fif, fid;
    int   phase, off;
    streak = 0; flushing = 0; terr = 0; m_stall = 0; m_flush = 0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      phase = (cyc / 40) % 4;
      off   = cyc % 40;
      rst          = !(cyc < 3 || (phase == 3 && (off == 12 || off == 13)));
      id_rs1_raddr = pick_reg();
      id_rs2_raddr = pick_reg();
      ex_rd_waddr  = pick_reg();
      id_rs1_used  = 1'($urandom_range(0, 1));
      id_rs2_used  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0, 1, 2: ex_mem_rw = 2'b01;
        3:       ex_mem_rw = 2'b10;
        default: ex_mem_rw = 2'b00;
      endcase
      ex_br_taken  = ($urandom_range(0, 99) < 15);
      ex_br_target = $urandom;
      case (phase)
        0: begin mem_req = ($urandom_range(0, 99) < 25); mem_ready = 1'($urandom_range(0, 1)); end
        1: begin mem_req = (off > 2); mem_ready = ($urandom_range(0, 99) < 3); end
        2: begin mem_req = ($urandom_range(0, 99) < 5); mem_ready = 1'b0; end
        default: begin mem_req = (off > 4 && off < 30); mem_ready = ($urandom_range(0, 99) < 10); end
      endcase
      #1;
      e.cyc = cyc;
      e.addr = 32'b0;
      e.perf = 64'b0;
      {jf, spc, sif, sid, sem, fif, fid} = 7'b0;
      if (!rst) begin
        e.ctrl = 8'b0;
        streak = 0; flushing = 0; terr = 0; m_stall = 0; m_flush = 0;
      end else begin
        mw = mem_req && !mem_ready;
        lu = (ex_mem_rw == 2'b01) && (ex_rd_waddr != 0) &&
             ((id_rs1_used && id_rs1_raddr == ex_rd_waddr) || (id_rs2_used && id_rs2_raddr == ex_rd_waddr));
`ifdef HAZARD_PERF_CNT_EN
        e.perf = {m_stall, m_flush};
`endif
        e.ctrl[0] = terr;
        if (mw) begin
          streak++;
          flushing = 0;
          if (streak == MEM_TIMEOUT) begin
            streak = 0; terr = 1; fid = 1;
          end else begin
            {spc, sif, sid, sem} = 4'b1111;
          end
        end else begin
          streak = 0;
          if (flushing) begin
            fif = 1; flushing = 0;
          end else if (ex_br_taken) begin
            jf = 1; fif = 1; fid = 1; flushing = 1;
            e.addr = ex_br_target;
          end else if (lu) begin
            spc = 1; sif = 1; fid = 1;
          end
        end
        e.ctrl[7:1] = {jf, spc, sif, sid, sem, fif, fid};
        if (spc && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (jf && m_flush != 32'hFFFF_FFFF) m_flush++;
      end
      exp_q.push_back(e);
    end
    @(negedge clk);
    #3;
    check("queue_drained", NCYC, 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
